// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_pkg - shared widths, reset PC and fetch FSM encoding for the fetch stage
// Rev 1.0
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam int          ADDR_W_DEF   = 10;
  localparam int          INST_W_DEF   = 32;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/mips_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_fetch_queue - synchronous prefetch FIFO with flush; pointers wrap mod DEPTH
// Rev 1.0
// ----------------------------------------------------------------------------
module mips_fetch_queue
  import mips_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF + INST_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) entries_q[wr_ptr_q] <= push_data;
  end

  assign count     = count_q;
  assign head_data = entries_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_fetch_unit - credit-based instruction fetch with prefetch queue and redirect
// Rev 1.0
// ----------------------------------------------------------------------------
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          INST_W   = INST_W_DEF,
  parameter int          QDEPTH   = 4,
  parameter int          MAX_OUT  = 2,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fetch_en,
  output logic                           imem_req_valid,
  input  logic                           imem_req_ready,
  output logic [ADDR_W-1:0]              imem_req_addr,
  input  logic                           imem_resp_valid,
  input  logic [INST_W-1:0]              imem_resp_data,
  output logic                           inst_valid,
  input  logic                           inst_ready,
  output logic [INST_W-1:0]              inst_data,
  output logic [ADDR_W-1:0]              inst_pc,
  input  logic                           redirect_valid,
  input  logic [ADDR_W-1:0]              redirect_pc,
  output logic [$clog2(MAX_OUT+1)-1:0]   outstanding
);

  localparam int                OUT_W = $clog2(MAX_OUT+1);
  localparam int                CNT_W = $clog2(QDEPTH+1);
  localparam int                ENT_W = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [OUT_W-1:0]  drop_q, drop_d;

  logic [CNT_W-1:0]  qcount;
  logic [ENT_W-1:0]  head_entry;
  logic              req_valid;
  logic              req_fire;
  logic              q_push;
  logic              q_pop;

  // Credit rule: in-flight plus queued never exceeds the queue, so responses always land.
  always_comb begin
    req_valid = (state_q == ST_FETCH) && !redirect_valid &&
                (32'(out_q) < MAX_OUT) &&
                ((32'(out_q) + 32'(qcount)) < QDEPTH);
    req_fire  = req_valid && imem_req_ready;
    q_push    = imem_resp_valid && !redirect_valid && (drop_q == '0);
    q_pop     = inst_valid && inst_ready && !redirect_valid;
  end

  always_comb begin
    state_d  = fetch_en ? ST_FETCH : ST_IDLE;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    out_d    = out_q + OUT_W'(req_fire) - OUT_W'(imem_resp_valid);
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      drop_d   = out_q - OUT_W'(imem_resp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_W'(1);
      if (q_push)   rsp_pc_d = rsp_pc_q + ADDR_W'(1);
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RST_PC;
      rsp_pc_q <= RST_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  mips_fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({rsp_pc_q, imem_resp_data}),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .count     (qcount),
    .head_data (head_entry)
  );

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign outstanding    = out_q;
  assign inst_valid     = (qcount != '0);
  assign inst_data      = inst_valid ? head_entry[INST_W-1:0] : '0;
  assign inst_pc        = inst_valid ? head_entry[ENT_W-1:INST_W] : RST_PC;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mips_fetch_unit - randomized bench with queue-based reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mips_fetch_unit;

  localparam int ADDR_W  = 10;
  localparam int INST_W  = 32;
  localparam int QDEPTH  = 4;
  localparam int MAX_OUT = 2;
  localparam int OUT_W   = $clog2(MAX_OUT+1);
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fetch_en = 1'b0;
  logic              imem_req_valid;
  logic              imem_req_ready = 1'b0;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid = 1'b0;
  logic [INST_W-1:0] imem_resp_data = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [OUT_W-1:0]  outstanding;

  always #5 clk = ~clk;

  mips_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .QDEPTH   (QDEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en        (fetch_en),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .outstanding     (outstanding)
  );

  typedef struct { logic [ADDR_W-1:0] pc; logic [INST_W-1:0] data; } qent_t;
  typedef struct { logic [ADDR_W-1:0] addr; int due; } mreq_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: fetch flag, PCs, credit counts and the queue contents.
  logic              m_fetch;
  logic [ADDR_W-1:0] m_pc, m_rsp_pc, sb_pc;
  int                m_out, m_drop;
  qent_t             mq[$];
  qent_t             pops[$];
  mreq_t             mem_q[$];
  int                last_due = 0;

  logic              d_fe = 0, d_rdy = 0, d_ir = 0, d_redir = 0;
  logic [ADDR_W-1:0] d_rpc = '0;
  int                lat = 1;
  logic [INST_W-1:0] key = '0;
  int                first_acc_cyc, first_valid_cyc, max_out_seen;

  function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return key ^ {{(INST_W-ADDR_W){1'b0}}, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fetch  = 1'b0;
    m_pc     = RESET_PC;
    m_rsp_pc = RESET_PC;
    sb_pc    = RESET_PC;
    m_out    = 0;
    m_drop   = 0;
    mq.delete();
    pops.delete();
    mem_q.delete();
  endtask

  // One clock: drive inputs at negedge, compare, then advance the model past the posedge.
  task automatic cycle();
    logic              rv, e_req, e_iv, fire;
    logic [INST_W-1:0] rd;
    int                due, pre_size;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv = 1'b1;
      rd = mem_word(mem_q[0].addr);
      mem_q.delete(0);
    end
    fetch_en        = d_fe;
    imem_req_ready  = d_rdy;
    inst_ready      = d_ir;
    redirect_valid  = d_redir;
    redirect_pc     = d_rpc;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    #1;
    e_req = m_fetch && !d_redir && (m_out < MAX_OUT) && (m_out + mq.size() < QDEPTH);
    e_iv  = (mq.size() != 0);
    chk("req_valid", imem_req_valid, e_req);
    if (e_req) chk("req_addr", imem_req_addr, m_pc);
    chk("outstanding", outstanding, m_out);
    chk("inst_valid", inst_valid, e_iv);
    if (e_iv) begin
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_data", inst_data, mq[0].data);
    end
    // Decode must see consecutive PCs from the last reset/redirect, with matching memory words.
    if (inst_valid && d_ir && !d_redir) begin
      chk("stream_pc", inst_pc, sb_pc);
      chk("stream_data", inst_data, mem_word(sb_pc));
      pops.push_back('{pc: inst_pc, data: inst_data});
      sb_pc = sb_pc + 1'b1;
    end
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (int'(outstanding) > max_out_seen) max_out_seen = int'(outstanding);

    fire = e_req && d_rdy;
    if (fire) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: m_pc, due: due});
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
    end
    if (d_redir) begin
      mq.delete();
      pops.delete();
      m_drop   = m_out - int'(rv);
      m_pc     = d_rpc;
      m_rsp_pc = d_rpc;
      sb_pc    = d_rpc;
    end else begin
      pre_size = mq.size();
      if (e_iv && d_ir) mq.delete(0);
      if (rv) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          chk("no_push_when_full", pre_size < QDEPTH, 1);
          mq.push_back('{pc: m_rsp_pc, data: rd});
          m_rsp_pc = m_rsp_pc + 1'b1;
        end
      end
      if (fire) m_pc = m_pc + 1'b1;
    end
    m_out   = m_out + int'(fire) - int'(rv);
    m_fetch = d_fe;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found, n0, out_before;
    model_reset();
    first_acc_cyc   = -1;
    first_valid_cyc = -1;
    max_out_seen    = 0;

    // Reset state
    #2;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_outstanding", outstanding, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait streaming, data = addr
    d_fe = 1; d_rdy = 1; d_ir = 1; lat = 1;
    repeat (4) cycle();
    n0 = pops.size();
    repeat (8) cycle();
    chk("t1_fill_latency", first_valid_cyc - first_acc_cyc, 2);
    chk("t1_throughput", pops.size() - n0, 8);
    chk("t1_max_out_le2", max_out_seen <= 2, 1);
    if (pops.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("t1_pc%0d", i), pops[i].pc, i);
    end else begin
      chk("t1_pop_count", pops.size(), 8);
    end

    // Decode stall fills the queue and throttles requests
    d_ir = 0;
    repeat (10) cycle();
    chk("t2_queue_full_pin", mq.size(), QDEPTH);
    chk("t2_req_stopped", imem_req_valid, 0);
    chk("t2_outstanding", outstanding, 0);
    chk("t2_head_valid", inst_valid, 1);
    d_ir = 1;
    repeat (10) cycle();

    // Latency 3, redirect with two requests in flight
    lat = 3;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      if (m_fetch && m_out == 2 && !(mem_q.size() > 0 && mem_q[0].due <= cyc)) begin
        found = 1;
        break;
      end
      cycle();
    end
    chk("t3_setup_reached", found, 1);
    if (found != 0) begin
      d_redir = 1; d_rpc = 10'h200;
      cycle();
      d_redir = 0;
      chk("t3_drop_pin", m_drop, 2);
      repeat (20) cycle();
      chk("t3_got_pops", pops.size() > 0, 1);
      if (pops.size() > 0) begin
        chk("t3_first_pc", pops[0].pc, 10'h200);
        chk("t3_first_data", pops[0].data, 32'h200);
      end
    end

    // Redirect coinciding with a stale response and a decode pop
    d_ir = 0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      if (mq.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc && m_out >= 2) begin
        found = 1;
        break;
      end
      cycle();
    end
    chk("t4_setup_reached", found, 1);
    if (found != 0) begin
      out_before = m_out;
      d_ir = 1; d_redir = 1; d_rpc = 10'h100;
      cycle();
      d_redir = 0;
      chk("t4_drop_pin", m_drop, out_before - 1);
      cycle();
      chk("t4_flushed", inst_valid, 0);
      repeat (20) cycle();
      if (pops.size() > 0) chk("t4_first_pc", pops[0].pc, 10'h100);
      else chk("t4_got_pops", pops.size(), 1);
    end

    // PC wrap at the top of the address space
    lat = 1; d_ir = 1;
    d_redir = 1; d_rpc = 10'h3FE;
    cycle();
    d_redir = 0;
    repeat (10) cycle();
    if (pops.size() >= 3) begin
      chk("t5_pc0", pops[0].pc, 10'h3FE);
      chk("t5_pc1", pops[1].pc, 10'h3FF);
      chk("t5_pc2", pops[2].pc, 10'h000);
    end else begin
      chk("t5_pop_count", pops.size(), 3);
    end

    // Asynchronous reset with a full queue
    d_ir = 0;
    repeat (12) cycle();
    chk("t7_full_pin", mq.size(), QDEPTH);
    chk("t7_valid_before", inst_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk("t7_inst_valid_async", inst_valid, 0);
    chk("t7_req_valid_async", imem_req_valid, 0);
    chk("t7_outstanding_async", outstanding, 0);
    model_reset();
    d_fe = 0; d_redir = 0;
    fetch_en = 0; imem_resp_valid = 0; redirect_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    d_fe = 1; d_ir = 1;
    cycle();
    cycle();
    chk("t7_first_req_valid", imem_req_valid, 1);
    chk("t7_first_req_addr", imem_req_addr, RESET_PC);

    // Randomized traffic, new memory content key
    key = $urandom();
    for (int k = 0; k < 3000; k++) begin
      d_fe    = ($urandom_range(0, 15) != 0);
      d_rdy   = ($urandom_range(0, 3) != 0);
      d_ir    = ($urandom_range(0, 2) != 0);
      d_redir = ($urandom_range(0, 19) == 0);
      d_rpc   = ($urandom_range(0, 3) == 0) ? ADDR_W'(10'h3FC + $urandom_range(0, 3))
                                           : ADDR_W'($urandom());
      lat     = $urandom_range(1, 4);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Parametrised instruction-fetch stage for the next-generation MIPS core. It replaces the fixed negedge array lookup with a request/response instruction-memory port that tolerates variable latency. A prefetch queue decouples fetch from decode, and a redirect path flushes the queue for branches and jumps. It sits between instruction memory and the decode/ControlUnit stage; PC is a word address.

Parameters:
ADDR_W, 10, PC / instruction-memory word-address width (1024-word space)
INST_W, 32, instruction width
QDEPTH, 4, prefetch queue entries; power of two, >=2
MAX_OUT, 2, max outstanding imem requests; 1..QDEPTH
RESET_PC, 0, PC loaded at reset

Ports:
clk  in  1  single clock, all state on posedge
rst  in  1  asynchronous, active-low reset
fetch_en  in  1  enables request issue
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word address requested
imem_resp_valid  in  1  response data valid; in order, one per accepted request, no backpressure
imem_resp_data  in  INST_W  instruction word
inst_valid  out  1  queue head valid to decode
inst_ready  in  1  decode consumes head
inst_data  out  INST_W  head instruction
inst_pc  out  ADDR_W  word PC of head instruction
redirect_valid  in  1  branch/jump taken; one-cycle pulse
redirect_pc  in  ADDR_W  new fetch PC
outstanding  out  $clog2(MAX_OUT+1)  in-flight request count, for debug and verification

Behaviour:
- Reset (rst=0, async): state=IDLE; pc=rsp_pc=RESET_PC; queue count, outstanding and drop_cnt = 0.
- Outputs under reset: imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC, inst_data=0, inst_pc=RESET_PC.
- FSM IDLE->FETCH: fetch_en=1 at a posedge.
- FSM FETCH->IDLE: fetch_en=0 at a posedge. In IDLE no new requests are issued; in-flight responses are still accepted or dropped.
- Issue rule: imem_req_valid = (state==FETCH) & !redirect_valid & (outstanding < MAX_OUT) & (outstanding + qcount < QDEPTH).
  - This credit rule guarantees every response has a queue slot.
  - imem_req_addr = pc.
  - On handshake (valid & ready): pc <= pc+1, modulo 2^ADDR_W wrap; outstanding increments.
- Response: outstanding decrements on each imem_resp_valid.
  - If drop_cnt>0: the response is discarded and drop_cnt decrements.
  - Otherwise: {rsp_pc, data} is written to the queue tail and rsp_pc <= rsp_pc+1.
  - Simultaneous issue and response: outstanding is unchanged.
- Decode handshake: inst_valid = qcount!=0, driven combinationally from the head entry. Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle: qcount is unchanged.
  - Push when full cannot occur (credit rule); the bench asserts this.
- Redirect (highest priority) in the cycle redirect_valid=1:
  - No request is issued.
  - Queue is flushed (qcount <= 0); any same-cycle pop is ignored.
  - pc <= redirect_pc; rsp_pc <= redirect_pc.
  - drop_cnt <= outstanding - imem_resp_valid, i.e. all still-in-flight stale responses.
  - A response arriving in the redirect cycle is discarded.
  - A redirect in IDLE updates pc and rsp_pc the same way.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Latency:
  - Redirect at cycle t: first new request no earlier than t+1.
  - With zero-wait memory (resp in the cycle after accept): instruction at inst_valid 2 cycles after request accept.
  - Steady-state throughput is 1 instr/cycle when MAX_OUT >= memory latency + 1.
- Reset mid-operation: all state clears immediately and asynchronously. Responses after reset deassertion are the memory's responsibility; the bench drives none.

Decomposition:
- Shared package mips_pkg: ADDR_W and INST_W defaults, RESET_PC, and the FSM state encoding (IDLE=0, FETCH=1).
- One sub-module: mips_fetch_queue.
  - Parametrised synchronous FIFO with width ADDR_W+INST_W, depth QDEPTH.
  - Ports: push, pop, flush, count, head data; async active-low reset on the same rst.
  - Pointers wrap modulo QDEPTH.
- The top handles the FSM, PC, credit counters and drop logic.

Test Plan:
- Reset then fetch_en=1, zero-wait memory returning data=addr, inst_ready=1 -> inst_pc 0,1,2,3... with inst_data equal to inst_pc; one instruction per cycle after the 2-cycle fill; outstanding <= 2.
- inst_ready=0 for 10 cycles -> exactly QDEPTH=4 entries queued; imem_req_valid drops once outstanding+qcount=4; after release, PCs continue with no gap or duplicate.
- Memory latency 3 cycles with 2 requests in flight, redirect_pc=0x200 -> both stale responses dropped; next inst_pc=0x200 with data 0x200.
- Redirect in the same cycle as a stale response plus an inst_ready pop -> queue empties, drop_cnt=outstanding-1, no stale instruction reaches decode.
- PC at 0x3FF -> next request addr 0x000 (wrap); inst_pc sequence 0x3FE, 0x3FF, 0x000.
- rst pulsed low mid-stream with a full queue -> inst_valid=0 and imem_req_valid=0 immediately; after release and fetch_en, first request addr = RESET_PC.
